// File: rtl/fill_pkg.sv
// Shared constants, state/owner encodings and address helper for the cache fill controller.
package fill_pkg;

   localparam int WORDS_PER_BLK = 8;
   localparam int MEM_LATENCY   = 4;
   localparam int ADDR_W        = 16;
   localparam int DATA_W        = 16;
   localparam int BLK_OFFSET_W  = 4;
   localparam int WORD_IDX_W    = 3;
   localparam int CNT_W         = WORD_IDX_W + 1;
   localparam int BASE_W        = ADDR_W - BLK_OFFSET_W;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } fill_state_t;

   typedef enum logic {
      OWN_I,
      OWN_D
   } owner_t;

   // Byte address of word idx inside the block selected by base.
   function automatic logic [ADDR_W-1:0] word_addr(input logic [BASE_W-1:0] base,
                                                   input logic [WORD_IDX_W-1:0] idx);
      return {base, idx, 1'b0};
   endfunction

endpackage

// File: rtl/cache_fill_ctrl_if.sv
// Cache-side and memory-side signals of the fill controller; master is the controller.
interface cache_fill_ctrl_if;
   import fill_pkg::*;

   logic              icache_miss;
   logic [ADDR_W-1:0] icache_addr;
   logic              dcache_miss;
   logic [ADDR_W-1:0] dcache_addr;

   logic              mem_enable;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_data_valid;
   logic [DATA_W-1:0] mem_data_in;

   logic [DATA_W-1:0]     fill_data;
   logic [WORD_IDX_W-1:0] fill_word;
   logic                  fill_we_i;
   logic                  fill_we_d;
   logic                  tag_we_i;
   logic                  tag_we_d;
   logic                  stall_i;
   logic                  stall_d;
   logic                  busy;

   modport master (
      input  icache_miss, icache_addr, dcache_miss, dcache_addr,
      input  mem_data_valid, mem_data_in,
      output mem_enable, mem_addr,
      output fill_data, fill_word, fill_we_i, fill_we_d,
      output tag_we_i, tag_we_d, stall_i, stall_d, busy
   );

   modport slave (
      output icache_miss, icache_addr, dcache_miss, dcache_addr,
      output mem_data_valid, mem_data_in,
      input  mem_enable, mem_addr,
      input  fill_data, fill_word, fill_we_i, fill_we_d,
      input  tag_we_i, tag_we_d, stall_i, stall_d, busy
   );

endinterface

// File: rtl/fill_counter.sv
// Clearable up-counter; term flags the increment that completes the last word of a block.
module fill_counter
   import fill_pkg::*;
#(
   parameter int W    = CNT_W,
   parameter int LAST = WORDS_PER_BLK - 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count,
   output logic         term
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + W'(1);
      end
   end

   assign term = enable && (count == W'(LAST));

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss handler: fetches one 8-word block from pipelined main memory into the I- or D-cache.
module cache_fill_ctrl
   import fill_pkg::*;
(
   input logic                clk,
   input logic                rst,
   cache_fill_ctrl_if.master  bus
);

   fill_state_t       state;
   fill_state_t       state_next;
   owner_t            owner;
   logic [BASE_W-1:0] base;

   logic [CNT_W-1:0] issue_cnt;
   logic [CNT_W-1:0] recv_cnt;
   logic             issue_en;
   logic             recv_en;
   logic             issue_last;
   logic             recv_last;
   logic             cnt_clear;
   logic             unused_bits;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // D-cache misses win when both caches miss in the same IDLE cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner <= OWN_I;
         base  <= '0;
      end else if (state == IDLE) begin
         if (bus.dcache_miss) begin
            owner <= OWN_D;
            base  <= bus.dcache_addr[ADDR_W-1:BLK_OFFSET_W];
         end else if (bus.icache_miss) begin
            owner <= OWN_I;
            base  <= bus.icache_addr[ADDR_W-1:BLK_OFFSET_W];
         end
      end
   end

   always_comb begin
      state_next     = state;
      issue_en       = 1'b0;
      recv_en        = 1'b0;
      cnt_clear      = 1'b0;
      bus.mem_enable = 1'b0;
      bus.tag_we_i   = 1'b0;
      bus.tag_we_d   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.dcache_miss || bus.icache_miss) begin
               state_next = ISSUE;
            end
         end
         ISSUE: begin
            bus.mem_enable = 1'b1;
            issue_en       = 1'b1;
            recv_en        = bus.mem_data_valid;
            if (issue_last) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            recv_en = bus.mem_data_valid;
            if (recv_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            bus.tag_we_i = (owner == OWN_I);
            bus.tag_we_d = (owner == OWN_D);
            cnt_clear    = 1'b1;
            state_next   = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   fill_counter #(.W(CNT_W), .LAST(WORDS_PER_BLK - 1)) u_issue_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .enable (issue_en),
      .count  (issue_cnt),
      .term   (issue_last)
   );

   fill_counter #(.W(CNT_W), .LAST(WORDS_PER_BLK - 1)) u_recv_cnt (
      .clk    (clk),
      .rst    (rst),
      .clear  (cnt_clear),
      .enable (recv_en),
      .count  (recv_cnt),
      .term   (recv_last)
   );

   assign bus.mem_addr  = word_addr(base, issue_cnt[WORD_IDX_W-1:0]);
   assign bus.fill_data = bus.mem_data_in;
   assign bus.fill_word = recv_cnt[WORD_IDX_W-1:0];
   assign bus.fill_we_i = recv_en && (owner == OWN_I);
   assign bus.fill_we_d = recv_en && (owner == OWN_D);
   assign bus.busy      = (state != IDLE);

   // Stalls look at the raw miss lines so the pipeline freezes in the very cycle the miss appears.
   assign bus.stall_d = bus.dcache_miss || (bus.busy && owner == OWN_D);
   assign bus.stall_i = bus.icache_miss || (bus.busy && owner == OWN_I) || bus.stall_d;

   assign unused_bits = ^{bus.icache_addr[BLK_OFFSET_W-1:0], bus.dcache_addr[BLK_OFFSET_W-1:0],
                          issue_cnt[CNT_W-1], recv_cnt[CNT_W-1]};

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: fixed-latency memory model plus a cycle-offset reference of each fill.
module tb_cache_fill_ctrl;
   import fill_pkg::*;

   logic clk = 1'b0;
   logic rst;
   cache_fill_ctrl_if bus();

   cache_fill_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [DATA_W-1:0] mem [0:(1 << (ADDR_W - 1)) - 1];
   int                ret_due  [$];
   logic [DATA_W-1:0] ret_data [$];

   // Reference: a fill accepted in cycle t0 occupies cycles t0+1 .. t0+9+MEM_LATENCY.
   bit                m_active = 1'b0;
   int                m_t0     = 0;
   bit                m_own_d  = 1'b0;
   logic [BASE_W-1:0] m_base   = '0;

   bit                imiss = 1'b0;
   bit                dmiss = 1'b0;
   logic [ADDR_W-1:0] iaddr = '0;
   logic [ADDR_W-1:0] daddr = '0;
   bit                rst_req    = 1'b1;
   bit                stray_req  = 1'b0;
   bit                rand_stray = 1'b0;
   bit                check_en   = 1'b0;
   int                drop_at    = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
      end
   endtask

   task automatic checkOutput();
      int                    rel;
      bit                    e_men;
      bit                    e_fill;
      bit                    e_tag;
      logic [WORD_IDX_W-1:0] w;
      logic [ADDR_W-1:0]     e_addr;
      bit                    e_sd;
      rel    = cyc - m_t0;
      e_men  = m_active && rel >= 1 && rel <= WORDS_PER_BLK;
      e_fill = m_active && rel >= 1 + MEM_LATENCY && rel <= WORDS_PER_BLK + MEM_LATENCY;
      e_tag  = m_active && rel == WORDS_PER_BLK + 1 + MEM_LATENCY;
      e_addr = ADDR_W'(m_base) * 16 + ADDR_W'(2 * (rel - 1));
      w      = WORD_IDX_W'(rel - 1 - MEM_LATENCY);
      e_sd   = dmiss || (m_active && m_own_d);
      chk("busy", 32'(bus.busy), 32'(m_active));
      chk("mem_enable", 32'(bus.mem_enable), 32'(e_men));
      if (e_men) chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
      chk("fill_we_i", 32'(bus.fill_we_i), 32'(e_fill && !m_own_d));
      chk("fill_we_d", 32'(bus.fill_we_d), 32'(e_fill && m_own_d));
      if (e_fill) begin
         chk("fill_word", 32'(bus.fill_word), 32'(w));
         chk("fill_data", 32'(bus.fill_data), 32'(mem[{m_base, w}]));
      end
      chk("tag_we_i", 32'(bus.tag_we_i), 32'(e_tag && !m_own_d));
      chk("tag_we_d", 32'(bus.tag_we_d), 32'(e_tag && m_own_d));
      chk("stall_d", 32'(bus.stall_d), 32'(e_sd));
      chk("stall_i", 32'(bus.stall_i), 32'(imiss || (m_active && !m_own_d) || e_sd));
   endtask

   // One clock cycle: drive inputs after the edge, check mid-cycle, then advance the reference.
   task automatic applyStimulus();
      bit tag_now;
      @(posedge clk);
      #1;
      rst             = rst_req;
      bus.icache_miss = imiss;
      bus.icache_addr = iaddr;
      bus.dcache_miss = dmiss;
      bus.dcache_addr = daddr;
      if (ret_due.size() > 0 && ret_due[0] == cyc) begin
         bus.mem_data_valid = 1'b1;
         bus.mem_data_in    = ret_data.pop_front();
         void'(ret_due.pop_front());
      end else begin
         bus.mem_data_valid = stray_req;
         bus.mem_data_in    = DATA_W'($urandom);
      end
      #1;
      if (check_en) checkOutput();
      if (bus.mem_enable === 1'b1) begin
         ret_due.push_back(cyc + MEM_LATENCY);
         ret_data.push_back(mem[bus.mem_addr[ADDR_W-1:1]]);
      end
      tag_now = m_active && (cyc - m_t0) == WORDS_PER_BLK + 1 + MEM_LATENCY;
      if (tag_now && m_own_d) dmiss = 1'b0;
      if (tag_now && !m_own_d) imiss = 1'b0;
      if (rst_req) begin
         m_active = 1'b0;
      end else if (!m_active) begin
         if (bus.dcache_miss || bus.icache_miss) begin
            m_active = 1'b1;
            m_t0     = cyc;
            m_own_d  = bus.dcache_miss;
            m_base   = bus.dcache_miss ? bus.dcache_addr[ADDR_W-1:BLK_OFFSET_W]
                                       : bus.icache_addr[ADDR_W-1:BLK_OFFSET_W];
         end
      end else if (tag_now) begin
         m_active = 1'b0;
      end
      cyc++;
   endtask

   task automatic run_until_idle(input int budget);
      int n;
      n = 0;
      while ((m_active || imiss || dmiss) && n < budget) begin
         if (drop_at > 0 && m_active && !m_own_d && (cyc - m_t0) == drop_at) imiss = 1'b0;
         stray_req = rand_stray && !m_active && ret_due.size() == 0 && ($urandom_range(0, 3) == 0);
         applyStimulus();
         n++;
      end
      stray_req = 1'b0;
      total++;
      assert (n < budget) else begin
         bad++;
         $error("[TB] FAIL drain_timeout: cycles=%0d limit=%0d", n, budget);
      end
   endtask

   initial begin
      int mode;
      rst                = 1'b1;
      bus.icache_miss    = 1'b0;
      bus.icache_addr    = '0;
      bus.dcache_miss    = 1'b0;
      bus.dcache_addr    = '0;
      bus.mem_data_valid = 1'b0;
      bus.mem_data_in    = '0;
      for (int i = 0; i < (1 << (ADDR_W - 1)); i++) mem[i] = DATA_W'($urandom);

      $display("[TB] reset");
      applyStimulus();
      check_en = 1'b1;
      applyStimulus();
      rst_req = 1'b0;
      repeat (2) applyStimulus();

      $display("[TB] single I miss at 0x0046 with 0xA000+idx data");
      for (int k = 0; k < WORDS_PER_BLK; k++) mem[(16'h0040 >> 1) + k] = 16'hA000 + DATA_W'(k);
      imiss = 1'b1;
      iaddr = 16'h0046;
      run_until_idle(40);

      $display("[TB] simultaneous I and D miss");
      imiss = 1'b1;
      iaddr = 16'h2F08;
      dmiss = 1'b1;
      daddr = 16'h1234;
      run_until_idle(60);

      $display("[TB] I miss dropped at cycle 3");
      imiss   = 1'b1;
      iaddr   = 16'h0BEE;
      drop_at = 3;
      run_until_idle(40);
      drop_at = 0;

      $display("[TB] reset in cycle 6 of a fill");
      imiss = 1'b1;
      iaddr = 16'h7770;
      repeat (6) applyStimulus();
      rst_req = 1'b1;
      imiss   = 1'b0;
      applyStimulus();
      rst_req = 1'b0;
      repeat (5) applyStimulus();
      imiss = 1'b1;
      iaddr = 16'h7770;
      run_until_idle(40);

      $display("[TB] stray returns while idle");
      stray_req = 1'b1;
      repeat (4) applyStimulus();
      stray_req = 1'b0;

      $display("[TB] randomized fills");
      rand_stray = 1'b1;
      for (int it = 0; it < 20; it++) begin
         mode  = int'($urandom_range(0, 3));
         iaddr = ADDR_W'($urandom);
         daddr = ADDR_W'($urandom);
         imiss = (mode != 1);
         dmiss = (mode == 1 || mode == 2);
         drop_at = (mode == 3) ? int'($urandom_range(1, 12)) : 0;
         run_until_idle(60);
         drop_at = 0;
         repeat ($urandom_range(0, 2)) applyStimulus();
      end
      rand_stray = 1'b0;
      applyStimulus();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
